// File: rtl/adc_strobe_gen_pkg.sv
// Shared types and default constants for the multi-channel ADC ready strobe generator.
// Build option: ADC_STROBE_SYNC_EN adds a two-flop synchroniser per ready line.
package adc_strobe_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2,
    STUCK = 2'd3
  } strobe_state_t;

  localparam int DEF_N_CH     = 2;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_MAX_HIGH = 64;

  // High counter must be able to hold MAX_HIGH itself.
  function automatic int hcnt_width(input int max_high);
    return $clog2(max_high + 1);
  endfunction

  localparam int DEF_HCNT_W = hcnt_width(DEF_MAX_HIGH);

endpackage

// File: rtl/adc_strobe_chan.sv
// One ready channel: optional synchroniser, sample flop, edge FSM, high and decimation counters.
// Build option: ADC_STROBE_SYNC_EN inserts a two-flop synchroniser ahead of the sample flop.
module adc_strobe_chan
  import adc_strobe_gen_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_HIGH = DEF_MAX_HIGH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [CNT_W-1:0] decim_ratio,
  input  logic             err_clr,
  input  logic             adc_rdy,
  output logic             demod_rdy,
  output logic             stuck_err
);

  localparam int HCNT_W = hcnt_width(MAX_HIGH);
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(MAX_HIGH);
  localparam logic [HCNT_W-1:0] HCNT_SAT = {HCNT_W{1'b1}};

  logic rdy_src;

`ifdef ADC_STROBE_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], adc_rdy};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rdy_src = sync_q[1];
`else
  assign rdy_src = adc_rdy;
`endif

  strobe_state_t     state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic              strobe_q, strobe_d;
  logic              err_q, err_d;

  logic [HCNT_W-1:0] hcnt_inc;
  logic [CNT_W-1:0]  ratio_m1;
  logic              dec_hit;

  always_comb begin
    rdy_d    = rdy_src;
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    dcnt_d   = dcnt_q;
    strobe_d = 1'b0;
    err_d    = err_q & ~err_clr;

    hcnt_inc = (hcnt_q == HCNT_SAT) ? hcnt_q : hcnt_q + HCNT_W'(1);
    // Ratios 0 and 1 both mean every edge; >= keeps a lowered ratio from locking up.
    ratio_m1 = (decim_ratio == '0) ? '0 : decim_ratio - CNT_W'(1);
    dec_hit  = (dcnt_q >= ratio_m1);

    case (state_q)
      IDLE: begin
        if (rdy_q) begin
          if (enable) begin
            state_d  = PULSE;
            hcnt_d   = '0;
            strobe_d = dec_hit;
            dcnt_d   = dec_hit ? '0 : dcnt_q + CNT_W'(1);
          end else begin
            state_d = HOLD;
            hcnt_d  = hcnt_inc;
          end
        end
      end
      PULSE: begin
        if (rdy_q) begin
          state_d = HOLD;
          hcnt_d  = hcnt_inc;
        end else begin
          state_d = IDLE;
          hcnt_d  = '0;
        end
      end
      HOLD: begin
        if (!rdy_q) begin
          state_d = IDLE;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_inc;
          if (hcnt_inc >= HCNT_MAX) begin
            state_d = STUCK;
            err_d   = 1'b1;
          end
        end
      end
      STUCK: begin
        if (!rdy_q) begin
          state_d = IDLE;
          hcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        hcnt_d  = '0;
      end
    endcase

    if (!enable) begin
      dcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdy_q    <= 1'b0;
      state_q  <= IDLE;
      hcnt_q   <= '0;
      dcnt_q   <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdy_q    <= rdy_d;
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      dcnt_q   <= dcnt_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign demod_rdy = strobe_q;
  assign stuck_err = err_q;

endmodule

// File: rtl/adc_strobe_gen.sv
// N_CH independent ADC ready edge detectors with shared decimation ratio, enable and error clear.
// Build option: ADC_STROBE_SYNC_EN (see adc_strobe_chan) synchronises each ready line.
module adc_strobe_gen
  import adc_strobe_gen_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_HIGH = DEF_MAX_HIGH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [CNT_W-1:0] decim_ratio,
  input  logic             err_clr,
  input  logic [N_CH-1:0]  adc_rdy,
  output logic [N_CH-1:0]  demod_rdy,
  output logic [N_CH-1:0]  stuck_err
);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      adc_strobe_chan #(
        .CNT_W    (CNT_W),
        .MAX_HIGH (MAX_HIGH)
      ) u_chan (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .decim_ratio (decim_ratio),
        .err_clr     (err_clr),
        .adc_rdy     (adc_rdy[gi]),
        .demod_rdy   (demod_rdy[gi]),
        .stuck_err   (stuck_err[gi])
      );
    end
  endgenerate

endmodule
